// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, drives the instruction memory address and
// pairs each returned word with its PC in the IF/ID register; handles stalls, redirects and faults.
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 512
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_instr,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        fault,
  output logic [31:0] fault_pc
);

  localparam logic [31:0] LAST_ADDR = 32'(MEM_BYTES - 4);

  typedef enum logic {RUN, FAULT} state_t;

  state_t      r_state;
  logic [31:0] r_fetch_pc;
  logic        r_infl_valid;
  logic [31:0] r_infl_pc;
  logic        r_if_valid;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_instr;
  logic        r_fault;
  logic [31:0] r_fault_pc;

  logic w_redirect_legal;
  logic w_fetch_overrun;

  assign w_redirect_legal = (redirect_pc[1:0] == 2'b00) && (redirect_pc <= LAST_ADDR);
  assign w_fetch_overrun  = (r_fetch_pc > LAST_ADDR);

  // During a stall the in-flight address is re-presented so the memory repeats the same word.
  always_comb begin
    mem_addr = r_fetch_pc;
    if (redirect_valid)
      mem_addr = redirect_pc;
    else if (stall)
      mem_addr = r_infl_pc;
    else if (r_state == FAULT)
      mem_addr = 32'h0000_0000;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state      <= RUN;
      r_fetch_pc   <= RESET_PC;
      r_infl_valid <= 1'b0;
      r_infl_pc    <= 32'h0000_0000;
      r_if_valid   <= 1'b0;
      r_if_pc      <= 32'h0000_0000;
      r_if_instr   <= 32'h0000_0000;
      r_fault      <= 1'b0;
      r_fault_pc   <= 32'h0000_0000;
    end else if (redirect_valid) begin
      r_if_valid <= 1'b0;
      if (w_redirect_legal) begin
        r_infl_valid <= 1'b1;
        r_infl_pc    <= redirect_pc;
        r_fetch_pc   <= redirect_pc + 32'd4;
        r_state      <= RUN;
        r_fault      <= 1'b0;
      end else begin
        r_infl_valid <= 1'b0;
        r_state      <= FAULT;
        r_fault      <= 1'b1;
        r_fault_pc   <= redirect_pc;
      end
    end else if (!stall) begin
      if (r_state == RUN) begin
        r_if_valid <= r_infl_valid;
        r_if_pc    <= r_infl_pc;
        r_if_instr <= mem_instr;
        // An out-of-range sequential address is never treated as presented.
        if (w_fetch_overrun) begin
          r_state      <= FAULT;
          r_fault      <= 1'b1;
          r_fault_pc   <= r_fetch_pc;
          r_infl_valid <= 1'b0;
        end else begin
          r_infl_valid <= 1'b1;
          r_infl_pc    <= r_fetch_pc;
          r_fetch_pc   <= r_fetch_pc + 32'd4;
        end
      end else begin
        r_if_valid <= r_infl_valid;
      end
    end
  end

  assign if_valid = r_if_valid;
  assign if_pc    = r_if_pc;
  assign if_instr = r_if_instr;
  assign fault    = r_fault;
  assign fault_pc = r_fault_pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: stimulus pushes the expected PC/instruction stream,
// a negedge monitor compares each word presented in IF/ID; directed checks cover bubbles and faults.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] mem_addr;
  logic [31:0] mem_instr = 32'h0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        fault;
  logic [31:0] fault_pc;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        expQ[$];
  int          compared = 0;
  int          mismatched = 0;
  logic [31:0] imem [0:127];

  instr_fetch #(
    .RESET_PC (32'h0000_0000),
    .MEM_BYTES(512)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .mem_addr      (mem_addr),
    .mem_instr     (mem_instr),
    .if_valid      (if_valid),
    .if_pc         (if_pc),
    .if_instr      (if_instr),
    .fault         (fault),
    .fault_pc      (fault_pc)
  );

  always #5 clk = ~clk;

  // Instruction memory with one cycle read latency; out-of-range reads return a marker word.
  always @(posedge clk)
    mem_instr <= (mem_addr < 32'd512) ? imem[mem_addr[8:2]] : 32'hDEAD_BEEF;

  function automatic logic [31:0] instrAt(input logic [31:0] addr);
    case (addr)
      32'h0:   instrAt = 32'h0000_0013;
      32'h4:   instrAt = 32'h0010_0093;
      32'h8:   instrAt = 32'h0020_0113;
      default: instrAt = 32'hA500_0000 | addr;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    compared++;
    if (actual !== required) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, actual, required);
    end
  endtask

  task automatic expectInstr(input logic [31:0] pc);
    expQ.push_back({pc, instrAt(pc)});
  endtask

  task automatic applyStimulus(input logic st, input logic rv, input logic [31:0] rp);
    @(posedge clk);
    #1;
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rp;
    #1;
  endtask

  // The word in IF/ID leaves when decode accepts it or when a redirect squashes the stage.
  always @(negedge clk) begin
    if (!rst_n && if_valid) begin
      if (expQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_instr: got pc 0x%08h, required no valid instruction", if_pc);
      end else begin
        checkOutput("if_pc", if_pc, expQ[0].pc);
        checkOutput("if_instr", if_instr, expQ[0].instr);
        if (!stall || redirect_valid)
          void'(expQ.pop_front());
      end
    end
  end

  initial begin
    for (int i = 0; i < 128; i++)
      imem[i] = instrAt(32'(i * 4));

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    expectInstr(32'h00); expectInstr(32'h04); expectInstr(32'h08);
    expectInstr(32'h0C); expectInstr(32'h10);
    #1;
    checkOutput("reset_mem_addr", mem_addr, 32'h0);
    checkOutput("reset_if_valid", {31'b0, if_valid}, 32'h0);
    checkOutput("reset_if_pc", if_pc, 32'h0);
    checkOutput("reset_if_instr", if_instr, 32'h0);
    checkOutput("reset_fault", {31'b0, fault}, 32'h0);

    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("cycle1_if_valid", {31'b0, if_valid}, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);

    // Stall for three cycles while if_pc=4.
    applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("stall_mem_addr", mem_addr, 32'h8);
    applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);

    // Redirect to 0x40 while if_pc=0x10.
    expectInstr(32'h40); expectInstr(32'h44); expectInstr(32'h48);
    applyStimulus(1'b0, 1'b1, 32'h40);
    checkOutput("redirect_mem_addr", mem_addr, 32'h40);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("redirect_bubble", {31'b0, if_valid}, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);

    // Stall and redirect together: stall is ignored.
    expectInstr(32'h80); expectInstr(32'h84); expectInstr(32'h88);
    applyStimulus(1'b1, 1'b1, 32'h80);
    checkOutput("stall_redirect_mem_addr", mem_addr, 32'h80);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("stall_redirect_bubble", {31'b0, if_valid}, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);

    // Misaligned redirect target.
    applyStimulus(1'b0, 1'b1, 32'h42);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("misalign_fault", {31'b0, fault}, 32'h1);
    checkOutput("misalign_fault_pc", fault_pc, 32'h42);
    checkOutput("misalign_if_valid", {31'b0, if_valid}, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("fault_mem_addr", mem_addr, 32'h0);
    checkOutput("fault_held", {31'b0, fault}, 32'h1);

    expectInstr(32'h20); expectInstr(32'h24);
    applyStimulus(1'b0, 1'b1, 32'h20);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("recover_fault", {31'b0, fault}, 32'h0);
    checkOutput("recover_bubble", {31'b0, if_valid}, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);

    // Sequential run off the end of memory.
    expectInstr(32'h1F0); expectInstr(32'h1F4); expectInstr(32'h1F8); expectInstr(32'h1FC);
    applyStimulus(1'b0, 1'b1, 32'h1F0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("tail_bubble", {31'b0, if_valid}, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("overrun_fault", {31'b0, fault}, 32'h1);
    checkOutput("overrun_fault_pc", fault_pc, 32'h200);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("overrun_if_valid", {31'b0, if_valid}, 32'h0);
    checkOutput("overrun_fault_held", {31'b0, fault}, 32'h1);

    // Restart at 0, then assert reset asynchronously mid-cycle.
    expectInstr(32'h0);
    applyStimulus(1'b0, 1'b1, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("restart_fault", {31'b0, fault}, 32'h0);
    checkOutput("restart_bubble", {31'b0, if_valid}, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    #1;
    rst_n = 1'b1;
    #1;
    checkOutput("async_if_valid", {31'b0, if_valid}, 32'h0);
    checkOutput("async_if_pc", if_pc, 32'h0);
    checkOutput("async_if_instr", if_instr, 32'h0);
    checkOutput("async_fault", {31'b0, fault}, 32'h0);
    checkOutput("async_fault_pc", fault_pc, 32'h0);
    checkOutput("async_mem_addr", mem_addr, 32'h0);

    // Release again; the stream must restart from RESET_PC.
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    expectInstr(32'h0); expectInstr(32'h4); expectInstr(32'h8);
    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("queue_drained", 32'(expQ.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage that sits directly upstream of the instruction memory. It owns the program counter and drives the byte address into the memory, which returns a 32-bit word one cycle later. It aligns each returned word with the PC that produced it and registers both into the IF/ID pipeline register consumed by decode. It also handles hazard stalls, branch/jump redirects with wrong-path squash, and address faults.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset; must be word-aligned.
- MEM_BYTES, 512: instruction memory size in bytes; legal fetch addresses are 0 .. MEM_BYTES-4, word-aligned.

- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-high.
- stall  in  1  decode/hazard unit cannot accept a new instruction this cycle.
- redirect_valid  in  1  taken branch/jump/trap this cycle.
- redirect_pc  in  32  redirect target byte address.
- mem_addr  out  32  byte address to the instruction memory; combinational.
- mem_instr  in  32  memory read data; registered in memory, one cycle latency.
- if_valid  out  1  IF/ID register holds a valid instruction.
- if_pc  out  32  PC of if_instr.
- if_instr  out  32  fetched instruction.
- fault  out  1  fetch halted on an illegal address.
- fault_pc  out  32  offending address.

## Operation
- Registers:
  - fetch_pc: next address to present.
  - infl_valid/infl_pc: the address presented last cycle, whose data is on mem_instr this cycle.
  - IF/ID outputs.
  - state ∈ {RUN, FAULT}.
- Reset values: state=RUN, fetch_pc=RESET_PC, infl_valid=0, infl_pc=0, if_valid=0, if_pc=0, if_instr=0, fault=0, fault_pc=0.
- mem_addr:
  - redirect_valid: redirect_pc.
  - else if stall: infl_pc. The in-flight address is re-presented so that the memory returns the same word next cycle.
  - else if FAULT: 0.
  - else: fetch_pc.
- Priority per cycle: redirect > stall > normal advance.
- Normal advance (RUN, no stall, no redirect):
  - if_valid←infl_valid, if_pc←infl_pc, if_instr←mem_instr.
  - infl_valid←1, infl_pc←fetch_pc.
  - fetch_pc←fetch_pc+4, 32-bit wraparound arithmetic.
- Stall (no redirect): all registers hold.
- Redirect, legal target (aligned, < MEM_BYTES):
  - if_valid←0 (squash).
  - infl_valid←1, infl_pc←redirect_pc.
  - fetch_pc←redirect_pc+4.
  - state←RUN, fault←0.
  - Legal from either state.
- Redirect, illegal target (redirect_pc[1:0]≠0 or redirect_pc > MEM_BYTES-4):
  - state←FAULT, fault←1, fault_pc←redirect_pc.
  - if_valid←0, infl_valid←0.
- Sequential overrun: in RUN with no stall or redirect, if fetch_pc > MEM_BYTES-4:
  - That address is not counted as presented.
  - state←FAULT, fault←1, fault_pc←fetch_pc, infl_valid←0.
  - The in-flight word still advances into IF/ID this cycle.
- FAULT:
  - No new fetches.
  - Without stall: if_valid←infl_valid (drains to 0).
  - Only a legal redirect exits FAULT.
- Reset asserted mid-operation: all state returns to reset values immediately, and any in-flight word is discarded.

## Timing
- After reset release (cycle 0):
  - mem_addr=RESET_PC in cycle 0.
  - if_valid=1 with if_pc=RESET_PC from cycle 2.
- Steady state: one instruction per cycle, with if_pc incrementing by 4.
- Redirect in cycle N:
  - mem_addr=target in N.
  - if_valid=0 in N+1.
  - if_pc=target, if_valid=1 in N+2.
  - Penalty: 2 bubbles, one of them the squashed in-flight word.
- Stall in cycles N..N+k:
  - IF/ID outputs frozen through N+k+1.
  - The first new word appears at N+k+2.
  - No instruction is lost or duplicated.
- Stall and redirect in the same cycle: redirect is applied and the stall is ignored.
- Illegal redirect in cycle N: fault=1 from N+1, if_valid=0 from N+1.

## Test plan
- Reset release with memory preloaded 0x00000013, 0x00100093, 0x00200113 at 0/4/8:
  - if_pc 0,4,8 and the matching if_instr in cycles 2,3,4.
  - if_valid=0 in cycles 0-1.
- stall held for 3 cycles while if_pc=4:
  - if_pc/if_instr remain 4/0x00100093 throughout.
  - The following cycles show 8 and then 12, with no skip or repeat.
- redirect_valid with redirect_pc=0x40 while fetching at 0x10:
  - if_valid=0 the next cycle, then if_pc=0x40, 0x44.
  - Address 0x10's successor never appears.
- redirect_valid with stall in the same cycle, target 0x80: identical to the redirect-only result.
- redirect_pc=0x42:
  - fault=1, fault_pc=0x42, if_valid=0.
  - A later redirect to 0x20 clears fault, and if_pc=0x20 appears two cycles later.
- Sequential run up to 0x1FC with MEM_BYTES=512:
  - 0x1FC is delivered, then fault=1, fault_pc=0x200, and if_valid drops.
  - Reset asserted mid-run returns all outputs to their reset values asynchronously.
